// File: rtl/mult_prod_accum.sv
// Group accumulator behind the 3x3 multiplier: sums N_TERMS unsigned products per
// result and holds the registered total until downstream takes it.
module mult_prod_accum #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int DATA_W = 6;
    localparam int CNT_W  = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Zero-extended add; bit ACC_W of the result is the carry-out.
    function automatic logic [ACC_W:0] add_carry(input logic [ACC_W-1:0] a,
                                                 input logic [DATA_W-1:0] p);
        return {1'b0, a} + {{(ACC_W + 1 - DATA_W){1'b0}}, p};
    endfunction

    state_t             state_p0, state_nxt;
    logic [ACC_W-1:0]   acc_p0, acc_nxt;
    logic               ovf_p0, ovf_nxt;
    logic [CNT_W-1:0]   cnt_p0, cnt_nxt;
    logic [ACC_W-1:0]   sum_p1, sum_nxt;
    logic               sovf_p1, sovf_nxt;
    logic               vld_p1, vld_nxt;
    logic               beat;
    logic [ACC_W:0]     sum_ext;

    always_comb begin
        in_ready  = (state_p0 == ACCUM) && !clr;
        beat      = in_valid && in_ready;
        sum_ext   = add_carry(acc_p0, in_p);
        state_nxt = state_p0;
        acc_nxt   = acc_p0;
        ovf_nxt   = ovf_p0;
        cnt_nxt   = cnt_p0;
        sum_nxt   = sum_p1;
        sovf_nxt  = sovf_p1;
        vld_nxt   = vld_p1;

        case (state_p0)
            IDLE: state_nxt = ACCUM;
            ACCUM: begin
                if (beat) begin
                    if (cnt_p0 == LAST) begin
                        sum_nxt   = sum_ext[ACC_W-1:0];
                        sovf_nxt  = ovf_p0 | sum_ext[ACC_W];
                        vld_nxt   = 1'b1;
                        acc_nxt   = '0;
                        ovf_nxt   = 1'b0;
                        cnt_nxt   = '0;
                        state_nxt = HOLD;
                    end else begin
                        acc_nxt = sum_ext[ACC_W-1:0];
                        ovf_nxt = ovf_p0 | sum_ext[ACC_W];
                        cnt_nxt = cnt_p0 + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (vld_p1 && out_ready) begin
                    vld_nxt   = 1'b0;
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Abort overrides beats and handshakes; out_sum/out_ovf are left as-is.
        if (clr && (state_p0 != IDLE)) begin
            acc_nxt   = '0;
            ovf_nxt   = 1'b0;
            cnt_nxt   = '0;
            vld_nxt   = 1'b0;
            state_nxt = ACCUM;
        end
    end

    // Stage p0 (partial sum) and stage p1 (held result) registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0 <= IDLE;
            acc_p0   <= '0;
            ovf_p0   <= 1'b0;
            cnt_p0   <= '0;
            sum_p1   <= '0;
            sovf_p1  <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            acc_p0   <= acc_nxt;
            ovf_p0   <= ovf_nxt;
            cnt_p0   <= cnt_nxt;
            sum_p1   <= sum_nxt;
            sovf_p1  <= sovf_nxt;
            vld_p1   <= vld_nxt;
        end
    end

    assign out_valid = vld_p1;
    assign out_sum   = sum_p1;
    assign out_ovf   = sovf_p1;

endmodule

// File: tb/tb_mult_prod_accum.sv
// Bench for mult_prod_accum: three configurations share one stimulus stream and are
// compared each cycle against a group-sum reference model, plus directed result checks.
module tb_mult_prod_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, clr, in_valid, out_ready;
    logic [5:0] in_p;
    logic       rdy0, rdy1, rdy2, vld0, vld1, vld2, ovf0, ovf1, ovf2;
    logic [7:0] sum0, sum2;
    logic [5:0] sum1;

    mult_prod_accum #(.N_TERMS(4), .ACC_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy0),
        .in_p(in_p), .out_valid(vld0), .out_ready(out_ready), .out_sum(sum0), .out_ovf(ovf0));
    mult_prod_accum #(.N_TERMS(4), .ACC_W(6)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy1),
        .in_p(in_p), .out_valid(vld1), .out_ready(out_ready), .out_sum(sum1), .out_ovf(ovf1));
    mult_prod_accum #(.N_TERMS(1), .ACC_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy2),
        .in_p(in_p), .out_valid(vld2), .out_ready(out_ready), .out_sum(sum2), .out_ovf(ovf2));

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: a list of the beats in the current group plus the last result.
    int beats [3][$];
    int got_q [3][$];
    bit m_live [3];
    bit m_hold [3];
    int m_sum  [3];
    bit m_ovf  [3];
    bit prev_vld [3];

    function automatic int nt(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic int aw(input int i);
        return (i == 1) ? 6 : 8;
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int i, output bit r, output bit v, output bit o, output int s);
        case (i)
            0:       begin r = rdy0; v = vld0; o = ovf0; s = int'(sum0); end
            1:       begin r = rdy1; v = vld1; o = ovf1; s = int'(sum1); end
            default: begin r = rdy2; v = vld2; o = ovf2; s = int'(sum2); end
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            beats[i].delete();
            m_live[i]   = 1'b0;
            m_hold[i]   = 1'b0;
            m_sum[i]    = 0;
            m_ovf[i]    = 1'b0;
            prev_vld[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit v, input int p, input bit c, input bit r);
        for (int i = 0; i < 3; i++) begin
            int total;
            if (!m_live[i]) begin
                m_live[i] = 1'b1;
                continue;
            end
            if (c) begin
                beats[i].delete();
                m_hold[i] = 1'b0;
                continue;
            end
            if (m_hold[i]) begin
                if (r) m_hold[i] = 1'b0;
                continue;
            end
            if (v) begin
                beats[i].push_back(p);
                if (beats[i].size() == nt(i)) begin
                    total = 0;
                    for (int k = 0; k < beats[i].size(); k++) total += beats[i][k];
                    m_sum[i]  = total % (1 << aw(i));
                    m_ovf[i]  = (total >= (1 << aw(i)));
                    m_hold[i] = 1'b1;
                    beats[i].delete();
                end
            end
        end
    endtask

    // One clock cycle: compare at the falling edge, then advance the model on the rising edge.
    task automatic tick();
        bit r, v, o;
        int s;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sample(i, r, v, o, s);
            check_eq($sformatf("u%0d.in_ready", i), int'(r),
                     int'(rst_n && m_live[i] && !m_hold[i] && !clr));
            check_eq($sformatf("u%0d.out_valid", i), int'(v), int'(m_hold[i]));
            if (m_hold[i] || !rst_n) begin
                check_eq($sformatf("u%0d.out_sum", i), s, m_sum[i]);
                check_eq($sformatf("u%0d.out_ovf", i), int'(o), int'(m_ovf[i]));
            end
            if (v && !prev_vld[i]) got_q[i].push_back(int'(o) * 65536 + s);
            prev_vld[i] = v;
        end
        @(posedge clk);
        if (rst_n) model_edge(in_valid, int'(in_p), clr, out_ready);
        #1;
    endtask

    task automatic beat(input bit v, input int p);
        in_valid = v;
        in_p     = 6'(p);
        tick();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        beat(1'b1, 50);
        clr = 1'b0;
    endtask

    task automatic async_reset();
        bit r, v, o;
        int s;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            sample(i, r, v, o, s);
            check_eq($sformatf("u%0d.rst_out_valid", i), int'(v), 0);
            check_eq($sformatf("u%0d.rst_out_sum", i), s, 0);
            check_eq($sformatf("u%0d.rst_in_ready", i), int'(r), 0);
        end
    endtask

    task automatic clear_got();
        for (int i = 0; i < 3; i++) got_q[i].delete();
    endtask

    task automatic check_res(input int i, input string tag, input int n, input int e0, input int e1);
        check_eq({tag, ".count"}, got_q[i].size(), n);
        check_eq({tag, ".first"}, (got_q[i].size() > 0) ? got_q[i][0] : -1, e0);
        if (n > 1) check_eq({tag, ".second"}, (got_q[i].size() > 1) ? got_q[i][1] : -1, e1);
    endtask

    initial begin
        rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; in_p = '0; out_ready = 1'b1;
        #1;
        async_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Full-scale group, wrapping group, then a small group
        clear_got();
        repeat (4) beat(1'b1, 49);
        beat(1'b0, 0);
        for (int k = 1; k <= 4; k++) beat(1'b1, k);
        beat(1'b0, 0);
        beat(1'b0, 0);
        check_res(0, "w8_results", 2, 196, 10);
        check_res(1, "w6_results", 2, 65536 + 4, 10);

        // Backpressure with in_valid held high
        clear_got();
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) beat(1'b1, k);
        repeat (5) beat(1'b1, 33);
        out_ready = 1'b1;
        beat(1'b1, 33);
        beat(1'b1, 7);
        beat(1'b0, 0);
        check_res(0, "bp_results", 1, 10, 0);

        // Gaps and abort
        pulse_clr();
        clear_got();
        beat(1'b1, 7);
        beat(1'b0, 0);
        beat(1'b0, 0);
        beat(1'b1, 9);
        beat(1'b0, 0);
        clr = 1'b1;
        beat(1'b1, 20);
        clr = 1'b0;
        repeat (4) beat(1'b1, 1);
        beat(1'b0, 0);
        check_res(0, "clr_results", 1, 4, 0);
        check_res(1, "clr_results_w6", 1, 4, 0);

        // Reset mid-group, then reset during HOLD
        pulse_clr();
        clear_got();
        repeat (2) beat(1'b1, 5);
        async_reset();
        beat(1'b1, 5);
        rst_n = 1'b1;
        beat(1'b1, 5);
        repeat (4) beat(1'b1, 5);
        beat(1'b0, 0);
        check_res(0, "rst_grp_results", 1, 20, 0);
        clear_got();
        out_ready = 1'b0;
        repeat (4) beat(1'b1, 5);
        beat(1'b0, 0);
        async_reset();
        beat(1'b0, 0);
        rst_n = 1'b1;
        beat(1'b0, 0);
        out_ready = 1'b1;
        repeat (4) beat(1'b1, 5);
        beat(1'b0, 0);
        check_res(0, "rst_hold_results", 2, 20, 20);

        // Single-term configuration
        pulse_clr();
        clear_got();
        beat(1'b1, 63);
        beat(1'b1, 0);
        beat(1'b1, 0);
        beat(1'b0, 0);
        beat(1'b0, 0);
        check_res(2, "n1_results", 2, 63, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            clr       = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_p      = 6'($urandom_range(0, 63));
            out_ready = ($urandom_range(0, 2) != 0);
            if (!rst_n) begin
                if ($urandom_range(0, 3) == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end
            tick();
        end
        rst_n = 1'b1;
        clr = 1'b0;
        in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mult_prod_accum.md
# mult_prod_accum

Accumulator stage directly downstream of the 3x3 combinational multiplier. Consumes a stream of 6-bit products over a valid/ready handshake. Sums each group of N_TERMS consecutive products, such as one dot-product row, and presents the total on a registered valid/ready output with a wrap flag. Stalls upstream while a finished result is waiting to be taken.

## Interface
- N_TERMS, 4: products summed per result; legal range 1..256.
- ACC_W, 8: accumulator and result width; legal range 6..16. Values below 6 + clog2(N_TERMS) can wrap.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
- clr  in  1  synchronous abort: discards the partial sum and any pending result.
- in_valid  in  1  in_p holds a product.
- in_ready  out  1  block accepts a beat this cycle.
- in_p  in  6  unsigned product, 0..63 (multiplier range is 0..49).
- out_valid  out  1  out_sum and out_ovf hold a finished result.
- out_ready  in  1  downstream takes the result.
- out_sum  out  ACC_W  sum of the group, modulo 2^ACC_W.
- out_ovf  out  1  group sum exceeded 2^ACC_W - 1.

## Operation
- State: `state` ∈ {IDLE, ACCUM, HOLD}; registers `acc[ACC_W-1:0]`, `ovf`, `cnt[clog2(N_TERMS+1)-1:0]`.
- Reset (rst_n=0):
  - state=IDLE, acc=0, ovf=0, cnt=0.
  - out_valid=0, out_sum=0, out_ovf=0.
  - in_ready=0.
- IDLE → ACCUM unconditionally on the first clk edge after reset release.
- in_ready = (state==ACCUM) && !clr, combinational. A beat is accepted when in_valid && in_ready at a rising edge.
- ACCUM, accepted beat, cnt < N_TERMS-1:
  - acc ← acc + in_p, truncated to ACC_W.
  - ovf ← ovf | carry-out.
  - cnt ← cnt+1.
- ACCUM, accepted beat, cnt == N_TERMS-1:
  - out_sum ← acc + in_p (truncated); out_ovf ← ovf | carry-out; out_valid ← 1.
  - acc ← 0, ovf ← 0, cnt ← 0.
  - state ← HOLD.
- ACCUM, no beat: all registers hold. Gaps in in_valid are allowed anywhere within a group.
- HOLD:
  - in_ready=0; out_sum and out_ovf remain stable.
  - When out_valid && out_ready at an edge: out_valid ← 0, state ← ACCUM.
  - out_sum and out_ovf keep their last values after the handshake; they are don't-care while out_valid=0.
- clr=1 at an edge, from any state except IDLE:
  - acc=0, ovf=0, cnt=0, out_valid ← 0, state ← ACCUM.
  - An unaccepted result is dropped. in_p that cycle is not accepted.
  - clr takes priority over every other event in the same cycle.
- N_TERMS=1: every accepted beat produces a result, out_sum = in_p zero-extended, out_ovf=0.
- Arithmetic:
  - Unsigned only.
  - in_p is zero-extended to ACC_W before the add.
  - Carry-out is bit ACC_W of the (ACC_W+1)-bit sum.
  - ovf is sticky within a group only.

## Timing
- Result latency: out_valid rises on the edge that accepts the Nth beat and is visible in the following cycle.
- Throughput: at most one result per N_TERMS+1 cycles. HOLD lasts at least one cycle, so in_ready is low for at least one cycle between groups.
- No combinational path from in_valid or in_p to any output. out_* are registered.
- in_ready depends combinationally on clr and state only, never on in_valid.
- Reset mid-group or mid-HOLD: the partial sum and any pending result are lost. in_ready stays 0 until one edge after release.
- The upstream multiplier is combinational, so in_p must be stable before the edge on which in_valid && in_ready.

## Test plan
- N_TERMS=4, ACC_W=8:
  - Scenario: back-to-back beats 49,49,49,49 with out_ready=1.
  - Required: out_sum=196 and out_ovf=0 in cycle 5; in_ready=0 in cycle 5; next group accepted from cycle 6.
- N_TERMS=4, ACC_W=6:
  - Scenario: beats 49,49,49,49.
  - Required: out_sum=4 (196 mod 64) and out_ovf=1; the next group 1,2,3,4 yields out_sum=10, out_ovf=0.
- Backpressure:
  - Scenario: group 1,2,3,4 complete; out_ready held 0 for 5 cycles; in_valid held high.
  - Required: out_sum=10 stable and in_ready=0 throughout; one handshake on the cycle out_ready=1; accumulation resumes the next cycle.
- Gaps and clr:
  - Scenario: beats 7 and 9 with idle cycles between; clr for one cycle; then beats 1,1,1,1.
  - Required: no result emitted for 7,9; the beat coinciding with clr is not accepted; the result is 4.
- Reset mid-operation:
  - Scenario: assert rst_n=0 asynchronously after 2 of 4 beats, and separately during HOLD.
  - Required: out_valid=0, out_sum=0 and in_ready=0 immediately; after release, beats 5,5,5,5 give out_sum=20.
- N_TERMS=1:
  - Scenario: beats 63 then 0.
  - Required: two results, 63 then 0, each with out_ovf=0.
